inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter ISSUE_GAP, default 3, number of forced-NOP cycles after each issued instruction, matching the core's 4-cycle execute.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  byte address of the requested word.
REQ-007 imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 redirect_valid  in  1  one-cycle pulse; PC change requested.
REQ-010 redirect_pc  in  32  new fetch address, sampled when redirect_valid=1.
REQ-011 inst  out  32  instruction to the core's control stage; 32'h0 (NOP) when nothing is issued.
REQ-012 inst_valid  out  1  high in exactly the cycles where inst carries an issued instruction.

Function
REQ-013 Fetch FSM states: F_IDLE (no request), F_WAIT (request outstanding), F_DROP (request outstanding, response to be discarded).
REQ-014 F_IDLE->F_WAIT when buffer count plus outstanding requests is below 2; imem_req=1 and imem_addr=pc from the next cycle.
REQ-015 imem_req and imem_addr are held stable from assertion until the cycle imem_ack=1; there is at most one outstanding request.
REQ-016 F_WAIT with imem_ack=1 and no redirect: push imem_rdata into the buffer, pc<=pc+4, go to F_IDLE; a new request may assert the following cycle.
REQ-017 pc addition is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-018 Prefetch buffer is a 2-entry FIFO; push when full is impossible under REQ-014, and the implementation shall assert on it.
REQ-019 Issue counter gap_cnt: when gap_cnt=0 and the buffer is non-empty, inst<=head, inst_valid<=1, pop, gap_cnt<=ISSUE_GAP.
REQ-020 Otherwise inst<=0 and inst_valid<=0, and gap_cnt decrements while non-zero.
REQ-021 inst and inst_valid are registered; data acked at edge N is visible on inst no earlier than after edge N+1.
REQ-022 Redirect in F_IDLE: flush buffer, pc<=redirect_pc, stay in F_IDLE.
REQ-023 Redirect in F_WAIT without ack: flush, pc<=redirect_pc, go to F_DROP; in F_DROP the ack is discarded without push or pc increment, then go to F_IDLE.
REQ-024 Redirect and imem_ack in the same cycle: redirect wins, rdata is discarded, pc<=redirect_pc, go to F_IDLE.
REQ-025 Redirect in F_DROP: pc<=redirect_pc, remain in F_DROP.
REQ-026 On a redirect cycle no issue occurs (inst<=0); gap_cnt continues counting, so the in-flight core instruction completes.
REQ-027 A pop and a push in the same cycle are both honoured; the count is unchanged.

Reset
REQ-028 While rst=1, the following hold immediately: imem_req=0, imem_addr=RESET_PC, inst=0, inst_valid=0, pc=RESET_PC, buffer empty, gap_cnt=0, state F_IDLE.
REQ-029 An outstanding request cut by reset is abandoned; any imem_ack arriving after rst deasserts, in F_IDLE, is ignored.

Structure
REQ-030 The shared package fetch_pkg holds: the fetch state enum, the constant NOP_INST=32'h0, and the width constants XLEN=32 and BUF_DEPTH=2.
REQ-031 One sub-module, fetch_buffer: a 2-entry FIFO with push, pop, flush, and registered count/empty/full.

Verification
REQ-032 Reset is asserted mid-F_WAIT -> all outputs match REQ-028 in the same cycle. After release, imem_req=1 and imem_addr=0 within 1 cycle.
REQ-033 Memory acks 1 cycle after each req with rdata 0x00000102, 0x00000204, 0x00000308 -> inst shows these values in order, each separated by exactly 3 zero cycles; addresses are 0, 4, 8; buffer count never exceeds 2.
REQ-034 redirect_pc=0x100 is pulsed in F_WAIT, then ack arrives 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears on inst; the next imem_addr is 0x100.
REQ-035 redirect_pc=0x200 is pulsed in the same cycle as an ack of 0x00000102 -> the word is dropped; the next imem_addr is 0x200; the buffer is empty.
REQ-036 Ack latency is 5 cycles -> inst=0 throughout the wait; each word is issued 1 cycle after its ack once gap_cnt=0.
REQ-037 Start at RESET_PC=32'hFFFF_FFFC and ack two fetches -> addresses are 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   - fetch_state_e : fetch FSM states (F_IDLE / F_WAIT / F_DROP)
//   - NOP_INST      : word driven on inst when nothing is issued
//   - XLEN          : data/address width
//   - BUF_DEPTH     : prefetch buffer depth
//   - CNT_W         : width of the buffer occupancy count (0..BUF_DEPTH)
//   - pc_incr()     : next sequential fetch address (32-bit modulo)
package fetch_pkg;

  localparam int XLEN      = 32;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;

  localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_BYTES = 32'h0000_0004;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,  // no request outstanding
    F_WAIT = 2'd1,  // request outstanding, response will be kept
    F_DROP = 2'd2   // request outstanding, response will be discarded
  } fetch_state_e;

  // Sequential fetch address; wraps naturally at the top of the address space.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry prefetch FIFO between instruction memory and issue.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_push        write i_wdata at the tail
//   i_pop         drop the head entry
//   i_flush       empty the FIFO (wins over push and pop)
//   i_wdata       word to push
//   o_head        current head entry (valid when !o_empty)
//   o_count       registered occupancy (0..BUF_DEPTH)
//   o_empty       registered, count == 0
//   o_full        registered, count == BUF_DEPTH
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [XLEN-1:0]  i_wdata,
  output logic [XLEN-1:0]  o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [XLEN-1:0]  r_mem [BUF_DEPTH];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_empty;
  logic             r_full;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [CNT_W-1:0] w_count_nxt;

  // Qualify push/pop and compute the next occupancy.
  always_comb begin
    w_pop_ok    = i_pop & ~r_empty;
    // A simultaneous pop frees the slot the push needs.
    w_push_ok   = i_push & (~r_full | w_pop_ok);
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_W'(BUF_DEPTH));
      if (i_flush) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (w_pop_ok) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        if (w_push_ok) begin
          r_wr_ptr <= ~r_wr_ptr;
        end
      end
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/fetch_buffer_chk.sv
// fetch_buffer_chk: run-time check that the prefetch buffer is never
// pushed while full (the fetch gating is meant to make that unreachable).
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_push        push request into the buffer
//   i_full        buffer full flag
module fetch_buffer_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_push,
  input logic i_full
);

  // Flag any push presented to a full buffer outside reset.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_push && i_full))
        else $error("fetch_buffer_chk: push into full prefetch buffer");
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch front end for a multi-cycle core.
// Fetches words from instruction memory (one outstanding request), keeps up
// to two in a prefetch buffer and issues one instruction every ISSUE_GAP+1
// cycles, driving NOP in between. A redirect flushes the buffer, moves the
// PC and, if a request is in flight, discards its response.
// Ports:
//   i_clk             clock, all state on posedge
//   i_rst             asynchronous active-high reset
//   o_imem_req        fetch request (held until i_imem_ack)
//   o_imem_addr       byte address of the requested word (held with req)
//   i_imem_ack        one-cycle response strobe
//   i_imem_rdata      fetched word, valid with i_imem_ack
//   i_redirect_valid  one-cycle PC change request
//   i_redirect_pc     new fetch address
//   o_inst            issued instruction, NOP_INST otherwise
//   o_inst_valid      high exactly when o_inst carries an issued instruction
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     ISSUE_GAP = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_inst,
  output logic            o_inst_valid
);

  localparam int             GAP_W    = (ISSUE_GAP < 1) ? 1 : $clog2(ISSUE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP);

  fetch_state_e     r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_req;
  logic [XLEN-1:0]  r_addr;
  logic [XLEN-1:0]  r_inst;
  logic             r_inst_valid;
  logic [GAP_W-1:0] r_gap_cnt;

  fetch_state_e     w_state_nxt;
  logic [XLEN-1:0]  w_pc_nxt;
  logic [XLEN-1:0]  w_addr_nxt;
  logic             w_req_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic [XLEN-1:0]  w_inst_nxt;
  logic             w_inst_valid_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [XLEN-1:0]  w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;

  fetch_buffer u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (i_imem_rdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  fetch_buffer_chk u_buf_chk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_push),
    .i_full (w_full)
  );

  // Fetch FSM next-state, PC and request address.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      F_IDLE: begin
        if (i_redirect_valid) begin
          w_flush  = 1'b1;
          w_pc_nxt = i_redirect_pc;
        end else if (w_count < CNT_W'(BUF_DEPTH)) begin
          // Nothing is outstanding in F_IDLE, so occupancy alone bounds
          // buffered + in-flight words to BUF_DEPTH.
          w_state_nxt = F_WAIT;
          w_addr_nxt  = r_pc;
        end else begin
          w_state_nxt = F_IDLE;
        end
      end
      F_WAIT: begin
        if (i_redirect_valid) begin
          w_flush     = 1'b1;
          w_pc_nxt    = i_redirect_pc;
          // With the ack in the same cycle the stale word is simply dropped.
          w_state_nxt = i_imem_ack ? F_IDLE : F_DROP;
        end else if (i_imem_ack) begin
          w_push      = 1'b1;
          w_pc_nxt    = pc_incr(r_pc);
          w_state_nxt = F_IDLE;
        end else begin
          w_state_nxt = F_WAIT;
        end
      end
      F_DROP: begin
        if (i_redirect_valid) begin
          w_flush  = 1'b1;
          w_pc_nxt = i_redirect_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
        // The response to the abandoned request ends the drop.
        w_state_nxt = i_imem_ack ? F_IDLE : F_DROP;
      end
      default: begin
        w_state_nxt = F_IDLE;
      end
    endcase
    w_req_nxt = (w_state_nxt != F_IDLE);
  end

  // Issue pacing: one instruction, then GAP_LOAD forced NOP cycles.
  always_comb begin
    w_pop            = 1'b0;
    w_inst_nxt       = NOP_INST;
    w_inst_valid_nxt = 1'b0;
    w_gap_nxt        = r_gap_cnt;
    if (!i_redirect_valid && (r_gap_cnt == '0) && !w_empty) begin
      w_pop            = 1'b1;
      w_inst_nxt       = w_head;
      w_inst_valid_nxt = 1'b1;
      w_gap_nxt        = GAP_LOAD;
    end else if (r_gap_cnt != '0) begin
      // Keeps counting through redirects so the core's current op completes.
      w_gap_nxt = r_gap_cnt - GAP_W'(1);
    end else begin
      w_gap_nxt = r_gap_cnt;
    end
  end

  // Fetch state, PC and memory request registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= F_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Issue output and gap counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      r_inst       <= w_inst_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_gap_cnt    <= w_gap_nxt;
    end
  end

  assign o_imem_req   = r_req;
  assign o_imem_addr  = r_addr;
  assign o_inst       = r_inst;
  assign o_inst_valid = r_inst_valid;

endmodule
